// File: rtl/sort_unit_flex.sv
// sort_unit_flex: pipelined bitonic sorter for p_nelems elements of p_nbits.
// One compare-exchange layer per pipeline stage, L = k(k+1)/2 stages for
// k = log2(p_nelems). The whole pipeline stalls as a unit when the output is
// valid but not accepted. Each stage carries its own desc bit, so ascending
// and descending vectors can be in flight together.
// Optional macro SORT_UNIT_FLEX_SIGNED_EN: compare elements as two's-complement
// signed values instead of unsigned.
module sort_unit_flex #(
  parameter int p_nbits  = 8,
  parameter int p_nelems = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic                        in_desc,
  input  logic [p_nelems*p_nbits-1:0] in_data,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_nelems*p_nbits-1:0] out_data
);

  localparam int K = $clog2(p_nelems);
  localparam int L = K * (K + 1) / 2;
  localparam int W = p_nelems * p_nbits;

  // Map a flat stage index onto (merge phase p, exchange distance exponent q).
  // Phases run p = 0..K-1; within phase p the distances are 2^p down to 2^0.
  function automatic int stage_p(input int s);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int p = 0; p < K; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (c == s) r = p;
        c = c + 1;
      end
    end
    return r;
  endfunction

  function automatic int stage_q(input int s);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int p = 0; p < K; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (c == s) r = q;
        c = c + 1;
      end
    end
    return r;
  endfunction

  // Strict "a > b" on element keys; equal keys never cause a swap.
  function automatic logic key_gt(input logic [p_nbits-1:0] a,
                                  input logic [p_nbits-1:0] b);
`ifdef SORT_UNIT_FLEX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  logic           val_reg  [L];
  logic           desc_reg [L];
  logic [W-1:0]   data_reg [L];
  logic           stall;

  assign stall    = val_reg[L-1] & ~out_rdy;
  assign in_rdy   = ~stall;
  assign out_val  = val_reg[L-1];
  assign out_data = val_reg[L-1] ? data_reg[L-1] : '0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < L; gi++) begin : g_stage
      localparam int P = stage_p(gi);
      localparam int D = 1 << stage_q(gi);

      logic         stage_val_in;
      logic         stage_desc_in;
      logic [W-1:0] stage_din;
      logic [W-1:0] stage_dout;

      if (gi == 0) begin : g_first
        assign stage_val_in  = in_val;
        assign stage_desc_in = in_desc;
        assign stage_din     = in_data;
      end else begin : g_next
        assign stage_val_in  = val_reg[gi-1];
        assign stage_desc_in = desc_reg[gi-1];
        assign stage_din     = data_reg[gi-1];
      end

      // Each element looks at its partner at distance D; both sides of a pair
      // compute the same swap decision, so the exchange stays consistent.
      for (gj = 0; gj < p_nelems; gj++) begin : g_elem
        localparam int PART     = gj ^ D;
        localparam bit LOWER    = ((gj & D) == 0);
        localparam bit BLK_DESC = (((gj >> (P + 1)) & 1) == 1);

        logic [p_nbits-1:0] self_v;
        logic [p_nbits-1:0] part_v;
        logic [p_nbits-1:0] lo_v;
        logic [p_nbits-1:0] hi_v;
        logic               swap;

        assign self_v = stage_din[gj*p_nbits +: p_nbits];
        assign part_v = stage_din[PART*p_nbits +: p_nbits];
        assign lo_v   = LOWER ? self_v : part_v;
        assign hi_v   = LOWER ? part_v : self_v;
        // Sub-block direction from the index, flipped by the vector's mode.
        assign swap   = (BLK_DESC ^ stage_desc_in) ? key_gt(hi_v, lo_v)
                                                   : key_gt(lo_v, hi_v);
        assign stage_dout[gj*p_nbits +: p_nbits] = swap ? part_v : self_v;
      end

      // Stage valid bit: cleared by reset, advances with the pipeline.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_reg[gi] <= 1'b0;
        end else if (!stall) begin
          val_reg[gi] <= stage_val_in;
        end
      end

      // Stage payload: no reset needed, only meaningful while valid.
      always_ff @(posedge clk) begin
        if (!stall) begin
          data_reg[gi] <= stage_dout;
          desc_reg[gi] <= stage_desc_in;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sort_unit_flex.sv
// Self-checking bench for sort_unit_flex (8x8 main instance plus 2- and
// 4-element instances). Expected vectors come from a plain sort of the input.
module tb_sort_unit_flex;

  localparam int L8 = 6;
  localparam int L4 = 3;
  localparam int L2 = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        in_val = 1'b0, in_rdy, in_desc = 1'b0, out_val, out_rdy = 1'b1;
  logic [63:0] in_data = '0, out_data;

  logic        in_val_2 = 1'b0, in_rdy_2, in_desc_2 = 1'b0, out_val_2;
  logic [15:0] in_data_2 = '0, out_data_2;
  logic        in_val_4 = 1'b0, in_rdy_4, in_desc_4 = 1'b0, out_val_4;
  logic [31:0] in_data_4 = '0, out_data_4;

  always #5 clk = ~clk;

  sort_unit_flex #(.p_nbits(8), .p_nelems(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_desc(in_desc), .in_data(in_data), .out_val(out_val),
    .out_rdy(out_rdy), .out_data(out_data));

  sort_unit_flex #(.p_nbits(8), .p_nelems(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_val(in_val_2), .in_rdy(in_rdy_2),
    .in_desc(in_desc_2), .in_data(in_data_2), .out_val(out_val_2),
    .out_rdy(1'b1), .out_data(out_data_2));

  sort_unit_flex #(.p_nbits(8), .p_nelems(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_val(in_val_4), .in_rdy(in_rdy_4),
    .in_desc(in_desc_4), .in_data(in_data_4), .out_val(out_val_4),
    .out_rdy(1'b1), .out_data(out_data_4));

  typedef struct {
    logic [63:0] data;
    int          acc;
    int          snap;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q4[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_cnt = 0;

  logic        nxt_v2 = 1'b0, nxt_v4 = 1'b0, nxt_ds = 1'b0;
  logic [15:0] nxt_d2 = '0;
  logic [31:0] nxt_d4 = '0;

  function automatic int key(input logic [7:0] a);
`ifdef SORT_UNIT_FLEX_SIGNED_EN
    return int'($signed(a));
`else
    return int'(a);
`endif
  endfunction

  // Reference: bubble sort of the first n elements by key.
  function automatic logic [63:0] model_sort(input logic [63:0] v, input int n,
                                             input bit desc);
    logic [7:0] e [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) e[i] = v[i*8 +: 8];
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if (desc ? (key(e[j]) < key(e[j+1])) : (key(e[j]) > key(e[j+1]))) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  function automatic logic [63:0] pack8(input logic [7:0] e [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, then
  // update the reference queues by the transfers the model predicts.
  task automatic cycle8(input bit v, input bit d, input logic [63:0] data,
                        input bit ordy, output bit accepted);
    bit ev, ev2, ev4;
    exp_t e;
    in_val = v; in_desc = d; in_data = data; out_rdy = ordy;
    in_val_2 = nxt_v2; in_data_2 = nxt_d2; in_desc_2 = nxt_ds;
    in_val_4 = nxt_v4; in_data_4 = nxt_d4; in_desc_4 = nxt_ds;
    #1;
    ev = (q8.size() > 0) && ((cyc - q8[0].acc - (stall_cnt - q8[0].snap)) >= L8);
    check("out_val8", out_val, ev);
    check("out_data8", out_data, ev ? q8[0].data : 64'd0);
    check("in_rdy8", in_rdy, !(ev && !ordy));
    accepted = v && !(ev && !ordy);
    if (ev && ordy) void'(q8.pop_front());
    if (ev && !ordy) stall_cnt++;
    if (accepted) begin
      e.data = model_sort(data, 8, d); e.acc = cyc; e.snap = stall_cnt;
      q8.push_back(e);
    end

    ev2 = (q2.size() > 0) && ((cyc - q2[0].acc) >= L2);
    check("out_val2", out_val_2, ev2);
    check("out_data2", out_data_2, ev2 ? q2[0].data : 64'd0);
    check("in_rdy2", in_rdy_2, 1'b1);
    if (ev2) void'(q2.pop_front());
    if (nxt_v2) begin
      e.data = model_sort({48'd0, nxt_d2}, 2, nxt_ds); e.acc = cyc; e.snap = 0;
      q2.push_back(e);
    end

    ev4 = (q4.size() > 0) && ((cyc - q4[0].acc) >= L4);
    check("out_val4", out_val_4, ev4);
    check("out_data4", out_data_4, ev4 ? q4[0].data : 64'd0);
    check("in_rdy4", in_rdy_4, 1'b1);
    if (ev4) void'(q4.pop_front());
    if (nxt_v4) begin
      e.data = model_sort({32'd0, nxt_d4}, 4, nxt_ds); e.acc = cyc; e.snap = 0;
      q4.push_back(e);
    end

    $display("cyc=%0d in_val=%0b desc=%0b in=%h acc=%0b out_val=%0b out=%h",
             cyc, v, d, data, accepted, out_val, out_data);
    @(negedge clk);
    cyc++;
    nxt_v2 = 1'b0; nxt_v4 = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle8(1'b0, 1'b0, 64'd0, 1'b1, a);
  endtask

  // Asynchronous reset pulse starting just after a falling edge.
  task automatic reset_pulse();
    in_val = 1'b0; in_val_2 = 1'b0; in_val_4 = 1'b0; out_rdy = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_out_val", out_val, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_rdy", in_rdy, 1'b1);
    q8.delete(); q2.delete(); q4.delete();
    $display("cyc=%0d reset asserted", cyc);
    @(negedge clk);
    cyc++;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] v027, v030;
    logic [63:0] vec29 [10];
    bit a;
    int k;

    v027 = pack8('{8'h07, 8'h03, 8'h05, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04});
    v030 = pack8('{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h02, 8'h81});

    // Reset state
    #1;
    check("init_out_val", out_val, 1'b0);
    check("init_out_data", out_data, 64'd0);
    check("init_in_rdy", in_rdy, 1'b1);
    check("init_out_val2", out_val_2, 1'b0);
    check("init_out_val4", out_val_4, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Single ascending vector
    cycle8(1'b1, 1'b0, v027, 1'b1, a);
    idle(8);

    // Descending then ascending back to back
    cycle8(1'b1, 1'b1, v027, 1'b1, a);
    cycle8(1'b1, 1'b0, v027, 1'b1, a);
    idle(8);

    // Ten back-to-back vectors with a 5-cycle output stall
    for (int i = 0; i < 10; i++) vec29[i] = {$urandom, $urandom};
    k = 0;
    for (int i = 0; i < 26; i++) begin
      cycle8(k < 10, 1'(i % 3 == 0), vec29[k < 10 ? k : 0],
             !(i >= 8 && i <= 12), a);
      if (a) k++;
    end
    check("stall_all_accepted", 64'(k), 64'd10);
    idle(4);

    // Signed/unsigned boundary vector
    cycle8(1'b1, 1'b0, v030, 1'b1, a);
    idle(8);

    // All-equal vectors on the 2- and 4-element instances
    nxt_v2 = 1'b1; nxt_d2 = 16'hAAAA; nxt_v4 = 1'b1; nxt_d4 = 32'hAAAAAAAA;
    nxt_ds = 1'b0;
    idle(5);

    // Random traffic on all instances with random backpressure
    for (int i = 0; i < 60; i++) begin
      nxt_v2 = 1'($urandom_range(0, 1)); nxt_d2 = 16'($urandom);
      nxt_v4 = 1'($urandom_range(0, 1)); nxt_d4 = $urandom;
      nxt_ds = 1'($urandom_range(0, 1));
      cycle8(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), a);
    end
    idle(8);

    // Reset with three vectors in flight; none may appear afterwards
    for (int i = 0; i < 3; i++) cycle8(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, a);
    reset_pulse();
    idle(10);
    cycle8(1'b1, 1'b1, v030, 1'b1, a);
    idle(8);

    check("drain_q8", 64'(q8.size()), 64'd0);
    check("drain_q2", 64'(q2.size()), 64'd0);
    check("drain_q4", 64'(q4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_unit_flex.md
SORT_UNIT_FLEX -- requirements
Module: sort_unit_flex

Interface
REQ-001 The block SHALL expose parameter p_nbits, default 8, element width in bits (legal 1..32).
REQ-002 The block SHALL expose parameter p_nelems, default 8, elements per vector (legal 2, 4, 8 only).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_val  input  1  input vector valid.
REQ-006 The block SHALL have port in_rdy  output  1  block can accept an input vector this cycle.
REQ-007 The block SHALL have port in_desc  input  1  per-vector mode (0 ascending, 1 descending), sampled with the vector.
REQ-008 The block SHALL have port in_data  input  p_nelems*p_nbits  unsorted vector; element i occupies bits [i*p_nbits +: p_nbits].
REQ-009 The block SHALL have port out_val  output  1  output vector valid.
REQ-010 The block SHALL have port out_rdy  input  1  consumer accepts the output vector.
REQ-011 The block SHALL have port out_data  output  p_nelems*p_nbits  sorted vector; element 0 is the smallest (ascending) or the largest (descending).

Function
REQ-012 The block SHALL sort with a bitonic network of L = k(k+1)/2 pipeline stages, k = log2(p_nelems), so L = 1, 3 or 6.
REQ-013 Each stage SHALL contain exactly one layer of compare-exchange units and one pipeline register, giving one comparison on each stage's critical path.
REQ-014 A transfer SHALL occur on a side when val and rdy are both 1 in the same cycle; a transferred input SHALL appear at out_val exactly L cycles later when there are no stalls.
REQ-015 The pipeline SHALL advance as a unit when stall = out_val & ~out_rdy is 0, and SHALL hold all stage registers when stall is 1.
REQ-016 in_rdy SHALL equal ~stall combinationally; the block SHALL NOT compress bubbles.
REQ-017 Each stage SHALL carry a valid bit and the desc bit alongside its data; every compare-exchange SHALL use its own stage's desc bit, so vectors with different modes can be in flight together.
REQ-018 Comparison SHALL be unsigned by default; for equal keys, the pair SHALL pass through unswapped.
REQ-019 out_data SHALL be driven all-zero whenever out_val is 0.
REQ-020 With in_val = 1 and in_rdy = 0, the input SHALL NOT be captured, and the producer holds it.
REQ-021 When the last stage transfers while the pipeline is full, a new input SHALL enter stage 1 in the same cycle (throughput of one vector per cycle).

Reset
REQ-022 Asserting reset (reset = 0) SHALL immediately clear all stage valid bits, so out_val = 0 and out_data = 0 while reset is low.
REQ-023 Stage data and desc registers SHALL NOT be reset; their contents are don't-care while the stage valid bit is 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight vectors; after release, the first accepted input SHALL emerge after L cycles.
REQ-025 in_rdy SHALL be 1 during reset and in the first cycle after release.

Configuration
REQ-026 With macro SORT_UNIT_FLEX_SIGNED_EN defined, all comparisons SHALL treat elements as two's-complement signed values; without it, comparisons SHALL be unsigned, and all other behaviour is identical.

Verification (p_nbits = 8, p_nelems = 8, L = 6 unless noted)
REQ-027 Input {07,03,05,01,08,02,06,04} with desc = 0 and out_rdy held at 1 -> 6 cycles later out_data = {01,02,03,04,05,06,07,08} and out_val = 1 for exactly one cycle.
REQ-028 The same input with desc = 1, followed next cycle by desc = 0 -> outputs {08..01} then {01..08} on consecutive cycles.
REQ-029 Ten back-to-back vectors with out_rdy held at 0 from cycle 8 to cycle 12 -> in_rdy = 0 during the stall, out_data is held stable, there is no loss or duplication, and output order matches input order.
REQ-030 Input {80,7F,FF,00,01,FE,02,81} with desc = 0 -> without the macro {00,01,02,7F,80,81,FE,FF}; with SORT_UNIT_FLEX_SIGNED_EN {80,81,FE,FF,00,01,02,7F}.
REQ-031 Reset asserted asynchronously with three vectors in flight -> out_val = 0 and out_data = 0 immediately; none of the three vectors appears after release.
REQ-032 For p_nelems = 2 and 4 with an all-equal vector {AA,...} -> out_data is unchanged, and latency is 1 and 3 cycles respectively.
